exc_sched: RTL and testbench

//  Exception/interrupt scheduler in front of the CP0 register block. Collects per-instruction

---
 rtl/exc_sched_pkg.sv | 62 ++++++
 rtl/exc_sched_timer.sv | 40 ++++
 rtl/exc_sched.sv | 133 +++++++++++++
 tb/tb_exc_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_sched_pkg.sv
// Shared constants, types and priority helper for the exception scheduler.
//   Exception codes, CP0 register numbers, FSM state encoding, request bit
//   positions, and exc_select() which picks the single winning request.
package exc_sched_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;
  localparam int unsigned INT_W = 6;
  localparam int unsigned REQ_W = 8;
  localparam int unsigned REG_W = 5;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'h00;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'h05;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'h08;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'h09;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'h0a;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'h0c;
  localparam logic [EXC_W-1:0] EXC_NONE = 5'h10;
  localparam logic [EXC_W-1:0] EXC_ERET = 5'h11;

  localparam logic [REG_W-1:0] CP0_COUNT   = 5'd9;
  localparam logic [REG_W-1:0] CP0_COMPARE = 5'd11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Request vector bit positions
  localparam int unsigned REQ_ADEL_IF = 0;
  localparam int unsigned REQ_RI      = 1;
  localparam int unsigned REQ_SYS     = 2;
  localparam int unsigned REQ_BP      = 3;
  localparam int unsigned REQ_OV      = 4;
  localparam int unsigned REQ_ADEL    = 5;
  localparam int unsigned REQ_ADES    = 6;
  localparam int unsigned REQ_ERET    = 7;

  typedef struct packed {
    logic             hit;        // something to dispatch
    logic [EXC_W-1:0] code;
    logic             use_pc;     // bad address comes from the PC
    logic             use_daddr;  // bad address comes from the data address
  } exc_sel_t;

  // Fixed-priority pick: interrupt first, then request bits low to high
  function automatic exc_sel_t exc_select(input logic take_int, input logic [REQ_W-1:0] req);
    exc_sel_t s;
    s = '{hit: 1'b1, code: EXC_NONE, use_pc: 1'b0, use_daddr: 1'b0};
    if (take_int)              s.code = EXC_INT;
    else if (req[REQ_ADEL_IF]) begin s.code = EXC_ADEL; s.use_pc = 1'b1; end
    else if (req[REQ_RI])      s.code = EXC_RI;
    else if (req[REQ_SYS])     s.code = EXC_SYS;
    else if (req[REQ_BP])      s.code = EXC_BP;
    else if (req[REQ_OV])      s.code = EXC_OV;
    else if (req[REQ_ADEL])    begin s.code = EXC_ADEL; s.use_daddr = 1'b1; end
    else if (req[REQ_ADES])    begin s.code = EXC_ADES; s.use_daddr = 1'b1; end
    else if (req[REQ_ERET])    s.code = EXC_ERET;
    else                       s.hit = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/exc_sched_timer.sv
// CP0 Count/Compare timer.
//   clk, rst      : clock, async active-high reset
//   we/waddr/wdata: snooped CP0 write port (Count = 9, Compare = 11)
//   timer_int     : set on count==compare (compare!=0), cleared by a Compare write
module exc_sched_timer
  import exc_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  output logic             timer_int
);

  logic            phase;
  logic [XLEN-1:0] count;
  logic [XLEN-1:0] compare;

  // Count advances on every second cycle; Compare write acknowledges the interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      phase <= ~phase;
      if (we && (waddr == CP0_COUNT)) count <= wdata;
      else if (phase)                 count <= count + XLEN'(1);
      if (we && (waddr == CP0_COMPARE)) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if ((compare != '0) && (count == compare)) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_sched.sv
// Exception/interrupt scheduler between the MEM stage and CP0.
//   Picks one exception or interrupt per eligible cycle by fixed priority and
//   drives exccode/pc/delay-slot/bad-address to CP0 in the same cycle, then
//   holds off for DRAIN_CYC cycles while the pipeline flush drains.
//   Inputs : cpu_clk_50M, cpu_rst (async, active-high), int_i, status_i, stall,
//            mem_valid_i, mem_pc_i, mem_in_delay_i, mem_exc_req_i, mem_daddr_i,
//            cp0_we_i, cp0_waddr_i, cp0_wdata_i
//   Outputs: exccode_o, exc_pc_o, exc_in_delay_o, exc_badaddr_o (combinational
//            dispatch), int_pend_o, busy_o, timer_int_o
//   Macro  : EXC_SCHED_TIMER_EN adds the Count/Compare timer on int_pend_o[5].
module exc_sched
  import exc_sched_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned STALL_W   = 6
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic [INT_W-1:0]   int_i,
  input  logic [XLEN-1:0]    status_i,
  input  logic [STALL_W-1:0] stall,
  input  logic               mem_valid_i,
  input  logic [XLEN-1:0]    mem_pc_i,
  input  logic               mem_in_delay_i,
  input  logic [REQ_W-1:0]   mem_exc_req_i,
  input  logic [XLEN-1:0]    mem_daddr_i,
  input  logic               cp0_we_i,
  input  logic [REG_W-1:0]   cp0_waddr_i,
  input  logic [XLEN-1:0]    cp0_wdata_i,
  output logic [EXC_W-1:0]   exccode_o,
  output logic [XLEN-1:0]    exc_pc_o,
  output logic               exc_in_delay_o,
  output logic [XLEN-1:0]    exc_badaddr_o,
  output logic [INT_W-1:0]   int_pend_o,
  output logic               busy_o,
  output logic               timer_int_o
);

  localparam int unsigned CNT_W = 4;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [INT_W-1:0] int_s1;
  logic [INT_W-1:0] int_s2;
  logic             timer_int;
  logic             take_int;
  logic             eligible;
  exc_sel_t         sel;

  // Two-flop synchroniser for the asynchronous interrupt lines
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      int_s1 <= '0;
      int_s2 <= '0;
    end else begin
      int_s1 <= int_i;
      int_s2 <= int_s1;
    end
  end

`ifdef EXC_SCHED_TIMER_EN
  exc_sched_timer u_timer (
    .clk       (cpu_clk_50M),
    .rst       (cpu_rst),
    .we        (cp0_we_i),
    .waddr     (cp0_waddr_i),
    .wdata     (cp0_wdata_i),
    .timer_int (timer_int)
  );
`else
  logic unused_cp0;
  assign unused_cp0 = ^{cp0_we_i, cp0_waddr_i, cp0_wdata_i};
  assign timer_int  = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{status_i, stall};

  assign int_pend_o  = int_s2 | {timer_int, {(INT_W-1){1'b0}}};
  assign timer_int_o = timer_int;
  assign busy_o      = (state == ST_DRAIN);

  assign take_int = status_i[0] & ~status_i[1] & (|(int_pend_o & status_i[15:10]));
  // Reset is gated in so nothing is dispatched while cpu_rst is held
  assign eligible = ~cpu_rst & mem_valid_i & ~stall[4];
  assign sel      = exc_select(take_int, mem_exc_req_i);

  // State and drain counter
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and zero-latency dispatch outputs
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    exccode_o      = EXC_NONE;
    exc_pc_o       = '0;
    exc_in_delay_o = 1'b0;
    exc_badaddr_o  = '0;
    case (state)
      ST_IDLE: begin
        if (eligible && sel.hit) begin
          exccode_o      = sel.code;
          exc_pc_o       = mem_pc_i;
          exc_in_delay_o = mem_in_delay_i;
          if (sel.use_pc)         exc_badaddr_o = mem_pc_i;
          else if (sel.use_daddr) exc_badaddr_o = mem_daddr_i;
          state_next = ST_DRAIN;
          cnt_next   = CNT_W'(DRAIN_CYC - 1);
        end
      end
      ST_DRAIN: begin
        // Everything presented here belongs to flushed instructions
        if (cnt == '0) state_next = ST_IDLE;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_sched.sv
// Testbench for exc_sched: directed scenarios plus random traffic, checked by
// a scoreboard against a cycle-level reference model of the scheduling rules.
module tb_exc_sched;
  import exc_sched_pkg::*;

  localparam int unsigned DRAIN_CYC = 3;
  localparam int unsigned STALL_W   = 6;

  logic               clk = 1'b0;
  logic               cpu_rst = 1'b1;
  logic [INT_W-1:0]   int_i = '0;
  logic [XLEN-1:0]    status_i = '0;
  logic [STALL_W-1:0] stall = '0;
  logic               mem_valid_i = 1'b0;
  logic [XLEN-1:0]    mem_pc_i = '0;
  logic               mem_in_delay_i = 1'b0;
  logic [REQ_W-1:0]   mem_exc_req_i = '0;
  logic [XLEN-1:0]    mem_daddr_i = '0;
  logic               cp0_we_i = 1'b0;
  logic [REG_W-1:0]   cp0_waddr_i = '0;
  logic [XLEN-1:0]    cp0_wdata_i = '0;
  logic [EXC_W-1:0]   exccode_o;
  logic [XLEN-1:0]    exc_pc_o;
  logic               exc_in_delay_o;
  logic [XLEN-1:0]    exc_badaddr_o;
  logic [INT_W-1:0]   int_pend_o;
  logic               busy_o;
  logic               timer_int_o;

  exc_sched #(.DRAIN_CYC(DRAIN_CYC), .STALL_W(STALL_W)) dut (
    .cpu_clk_50M    (clk),
    .cpu_rst        (cpu_rst),
    .int_i          (int_i),
    .status_i       (status_i),
    .stall          (stall),
    .mem_valid_i    (mem_valid_i),
    .mem_pc_i       (mem_pc_i),
    .mem_in_delay_i (mem_in_delay_i),
    .mem_exc_req_i  (mem_exc_req_i),
    .mem_daddr_i    (mem_daddr_i),
    .cp0_we_i       (cp0_we_i),
    .cp0_waddr_i    (cp0_waddr_i),
    .cp0_wdata_i    (cp0_wdata_i),
    .exccode_o      (exccode_o),
    .exc_pc_o       (exc_pc_o),
    .exc_in_delay_o (exc_in_delay_o),
    .exc_badaddr_o  (exc_badaddr_o),
    .int_pend_o     (int_pend_o),
    .busy_o         (busy_o),
    .timer_int_o    (timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [EXC_W-1:0] code;
    logic [XLEN-1:0]  pc;
    logic             dly;
    logic [XLEN-1:0]  bad;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 0;
  bit         chk_pend = 1;
  logic       exp_busy = 1'b0;
  logic [5:0] exp_pend = '0;

  // Reference model: cycles of drain still owed, and the int_i history
  int         drain_left = 0;
  logic [5:0] hist1 = '0;
  logic [5:0] hist2 = '0;

  // Exception code for each request bit; lower index wins
  logic [EXC_W-1:0] code_tab [REQ_W];
  initial begin
    code_tab[0] = EXC_ADEL; code_tab[1] = EXC_RI;   code_tab[2] = EXC_SYS;  code_tab[3] = EXC_BP;
    code_tab[4] = EXC_OV;   code_tab[5] = EXC_ADEL; code_tab[6] = EXC_ADES; code_tab[7] = EXC_ERET;
  end

  // Predict this cycle's visible behaviour from the inputs just driven
  task automatic model_step();
    exp_t e;
    bit   disp;
    bit   ti;
    disp = 0;
    if (cpu_rst) begin
      drain_left = 0; hist1 = '0; hist2 = '0;
      exp_busy = 1'b0; exp_pend = '0;
      mon_en = 1;
      return;
    end
    exp_busy = (drain_left > 0);
    exp_pend = hist2;
    ti = status_i[0] && !status_i[1] && ((hist2 & status_i[15:10]) != 6'd0);
    e = '{code: EXC_NONE, pc: mem_pc_i, dly: mem_in_delay_i, bad: 32'd0};
    if (!exp_busy && mem_valid_i && !stall[4]) begin
      if (ti) begin
        disp = 1; e.code = EXC_INT;
      end else begin
        for (int b = 0; b < REQ_W; b++) begin
          if (!disp && mem_exc_req_i[b]) begin
            disp = 1;
            e.code = code_tab[b];
            if (b == 0)           e.bad = mem_pc_i;
            else if (b == 5 || b == 6) e.bad = mem_daddr_i;
          end
        end
      end
    end
    if (disp) exp_q.push_back(e);
    hist2 = hist1;
    hist1 = int_i;
    if (disp)                drain_left = DRAIN_CYC;
    else if (drain_left > 0) drain_left = drain_left - 1;
    mon_en = 1;
  endtask

  task automatic cyc(input logic v, input logic [STALL_W-1:0] st, input logic [7:0] req,
                     input logic [31:0] pc, input logic [31:0] da, input logic dly,
                     input logic [5:0] iv, input logic [31:0] stat);
    @(negedge clk);
    cpu_rst = 1'b0; cp0_we_i = 1'b0;
    mem_valid_i = v; stall = st; mem_exc_req_i = req; mem_pc_i = pc;
    mem_daddr_i = da; mem_in_delay_i = dly; int_i = iv; status_i = stat;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, 8'h00, 32'h0, 32'h0, 1'b0, int_i, status_i);
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    cpu_rst = 1'b1; cp0_we_i = 1'b0;
    mem_valid_i = 1'b0; stall = '0; mem_exc_req_i = '0; int_i = '0;
    model_step();
  endtask

  // Monitor: compare DUT outputs with the scoreboard each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        checks++;
        if (busy_o !== exp_busy) begin
          errors++;
          $display("FAIL busy t=%0t: got %b expected %b", $time, busy_o, exp_busy);
        end
        if (chk_pend) begin
          checks++;
          if (int_pend_o !== exp_pend) begin
            errors++;
            $display("FAIL int_pend t=%0t: got %h expected %h", $time, int_pend_o, exp_pend);
          end
        end
        checks++;
        if (exccode_o !== EXC_NONE) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_dispatch t=%0t: got code %h expected none", $time, exccode_o);
          end else begin
            e = exp_q.pop_front();
            if (exccode_o !== e.code || exc_pc_o !== e.pc || exc_in_delay_o !== e.dly ||
                exc_badaddr_o !== e.bad) begin
              errors++;
              $display("FAIL dispatch t=%0t: got code=%h pc=%h dly=%b bad=%h expected code=%h pc=%h dly=%b bad=%h",
                       $time, exccode_o, exc_pc_o, exc_in_delay_o, exc_badaddr_o,
                       e.code, e.pc, e.dly, e.bad);
            end
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          errors++;
          $display("FAIL missed_dispatch t=%0t: got none expected code=%h", $time, e.code);
        end else if (exc_pc_o !== 32'h0 || exc_badaddr_o !== 32'h0 || exc_in_delay_o !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs t=%0t: got pc=%h bad=%h dly=%b expected zeros",
                   $time, exc_pc_o, exc_badaddr_o, exc_in_delay_o);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0]  r;
    logic [5:0]  cur_int;
    logic [31:0] stat;
    logic [31:0] ie_stat;
    ie_stat = 32'h0000_0401;  // IE=1, EXL=0, IM=6'h01

    rst_cyc(); rst_cyc();

    // Sys + Ov together: Sys wins, then three drain cycles
    cyc(1'b1, '0, 8'b0001_0100, 32'h0000_1000, 32'h0, 1'b0, 6'h00, 32'h0);
    idle(4);

    // Interrupt through the synchroniser
    cyc(1'b0, '0, 8'h00, 32'h0, 32'h0, 1'b0, 6'h01, ie_stat);
    cyc(1'b0, '0, 8'h00, 32'h0, 32'h0, 1'b0, 6'h01, ie_stat);
    cyc(1'b1, '0, 8'h02, 32'h0000_2000, 32'h0, 1'b1, 6'h01, ie_stat);
    cyc(1'b0, '0, 8'h00, 32'h0, 32'h0, 1'b0, 6'h00, 32'h0);
    idle(4);

    // AdES and AdEL-fetch bad addresses
    cyc(1'b1, '0, 8'h40, 32'h0000_3000, 32'h8000_1002, 1'b0, 6'h00, 32'h0);
    idle(3);
    cyc(1'b1, '0, 8'h21, 32'hBFC0_0004, 32'h1234_5678, 1'b1, 6'h00, 32'h0);
    idle(3);
    cyc(1'b1, '0, 8'h20, 32'h0000_4000, 32'h0000_0013, 1'b0, 6'h00, 32'h0);
    idle(3);

    // RI held off by MEM stall for four cycles
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 6'h10, 8'h02, 32'h0000_5000, 32'h0, 1'b0, 6'h00, 32'h0);
    cyc(1'b1, '0, 8'h02, 32'h0000_5000, 32'h0, 1'b0, 6'h00, 32'h0);
    idle(3);

    // Requests during DRAIN are dropped, including the last drain cycle
    cyc(1'b1, '0, 8'h08, 32'h0000_6000, 32'h0, 1'b0, 6'h00, 32'h0);
    for (int k = 0; k < 3; k++)
      cyc(1'b1, '0, 8'h04, 32'h0000_6004, 32'h0, 1'b0, 6'h00, 32'h0);
    cyc(1'b1, '0, 8'h04, 32'h0000_6008, 32'h0, 1'b0, 6'h00, 32'h0);
    idle(3);

    // ERET also drains
    cyc(1'b1, '0, 8'h80, 32'h0000_7000, 32'h0, 1'b0, 6'h00, 32'h0);
    idle(4);

    // Reset in the middle of DRAIN
    cyc(1'b1, '0, 8'h10, 32'h0000_8000, 32'h0, 1'b0, 6'h00, 32'h0);
    idle(1);
    rst_cyc();
    cyc(1'b1, '0, 8'h08, 32'h0000_8004, 32'h0, 1'b0, 6'h00, 32'h0);
    idle(3);

    // Random traffic
    cur_int = '0;
    for (int i = 0; i < 500; i++) begin
      r = '0;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) r[b] = 1'b1;
      if ($urandom_range(0, 7) == 0) cur_int = 6'($urandom);
      stat = 32'h0;
      stat[0] = ($urandom_range(0, 3) != 0);
      stat[1] = ($urandom_range(0, 3) == 0);
      stat[15:10] = 6'($urandom);
      cyc(($urandom_range(0, 3) != 0), STALL_W'($urandom) & ($urandom_range(0, 3) == 0 ? 6'h3F : 6'h2F),
          r, $urandom, $urandom, 1'($urandom), cur_int, stat);
    end
    idle(4);

`ifdef EXC_SCHED_TIMER_EN
    begin
      int n;
      chk_pend = 0;
      @(negedge clk);
      cp0_we_i = 1'b1; cp0_waddr_i = CP0_COMPARE; cp0_wdata_i = 32'd10;
      mem_valid_i = 1'b0; int_i = '0; status_i = '0;
      model_step();
      @(negedge clk);
      cp0_we_i = 1'b1; cp0_waddr_i = CP0_COUNT; cp0_wdata_i = 32'd0;
      model_step();
      n = 0;
      while (n < 60 && timer_int_o !== 1'b1) begin
        idle(1);
        n++;
      end
      checks++;
      if (n < 15 || n > 26) begin
        errors++;
        $display("FAIL timer_fire: got %0d cycles expected 15..26", n);
      end
      checks++;
      if (int_pend_o[5] !== 1'b1) begin
        errors++;
        $display("FAIL timer_pend: got %b expected 1", int_pend_o[5]);
      end
      @(negedge clk);
      cp0_we_i = 1'b1; cp0_waddr_i = CP0_COMPARE; cp0_wdata_i = 32'd5000;
      model_step();
      idle(1);
      checks++;
      if (timer_int_o !== 1'b0) begin
        errors++;
        $display("FAIL timer_clear: got %b expected 0", timer_int_o);
      end
    end
`endif

    @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
